bcd_hex4_feed: RTL



---
 rtl/bcd_hex4_feed.sv | 106 ++++++++++
 1 files changed

// File: rtl/bcd_hex4_feed.sv
// bcd_hex4_feed: 14-bit binary to 4-digit BCD feeder for the 7-segment
// scan driver, with a free-running scan clock-enable prescaler.
module bcd_hex4_feed #(
    parameter int SCAN_DIV = 4096
) (
    input  logic        clk4i,
    input  logic        reset_n,
    input  logic [13:0] bin,
    input  logic [3:0]  dot_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [15:0] num,
    output logic [3:0]  dot,
    output logic        ovf,
    output logic        clk4e
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t        state;
    logic [13:0]   sr;
    logic [15:0]   acc;
    logic [15:0]   adj;
    logic [15:0]   acc_nx;
    logic [3:0]    cnt;
    logic [3:0]    pdot;
    logic          povf;
    logic [CW-1:0] pcnt;

    // Add 3 to every BCD digit that is 5 or more before the next shift
    always_comb begin
        adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Carry out of the thousands digit is dropped; overflow is flagged apart
    assign acc_nx = {adj[14:0], sr[13]};

    // Conversion FSM: capture on load, 14 shift-add-3 steps, then publish
    always_ff @(posedge clk4i or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            pdot  <= '0;
            povf  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            num   <= '0;
            dot   <= '0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        sr    <= bin;
                        acc   <= '0;
                        pdot  <= dot_in;
                        povf  <= (bin > 14'd9999);
                        cnt   <= 4'd14;
                        busy  <= 1'b1;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc <= acc_nx;
                    sr  <= {sr[12:0], 1'b0};
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        num   <= povf ? 16'hFFFF : acc_nx;
                        dot   <= pdot;
                        ovf   <= povf;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Free-running scan prescaler; strobe follows the terminal count
    always_ff @(posedge clk4i or negedge reset_n) begin
        if (!reset_n) begin
            pcnt  <= '0;
            clk4e <= 1'b0;
        end else begin
            pcnt  <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
            clk4e <= (pcnt == LAST);
        end
    end

endmodule
